// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: tracks in-flight destinations (E, M, W, PostW) and drives stall, flush and operand selects.
// Define HAZARD_FORWARDING_EN for full forwarding; otherwise RAW hazards stall until the producer reaches PostW.
module hazard_forward_unit #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D,
  input  logic                      useRs1D,
  input  logic                      useRs2D,
  input  logic [REG_ADDR_WIDTH-1:0] rdD,
  input  logic                      regWriteD,
  input  logic [1:0]                resultSrcD,
  input  logic [1:0]                pcSrcE,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      flushD,
  output logic                      flushE,
  output logic [1:0]                rs1ForwardSrcE,
  output logic [1:0]                rs2ForwardSrcE
);

  localparam logic [1:0] RESULT_SRC_MEMORY = 2'd1;
  localparam logic [1:0] PC_SRC_PCP4_I     = 2'd0;
  localparam logic [1:0] FWD_NO_FORWARD    = 2'd0;
  localparam logic [1:0] FWD_COMPUTE       = 2'd1;
  localparam logic [1:0] FWD_RD1_W         = 2'd2;
  localparam logic [1:0] FWD_RD1_POSTW     = 2'd3;

  localparam int SLOT_E     = 0;
  localparam int SLOT_M     = 1;
  localparam int SLOT_W     = 2;
  localparam int SLOT_POSTW = 3;
  localparam int NUM_SLOTS  = 4;

  logic [REG_ADDR_WIDTH-1:0] rd_reg [NUM_SLOTS];
  logic                      wr_reg [NUM_SLOTS];
  logic                      ld_reg [NUM_SLOTS];
  logic [REG_ADDR_WIDTH-1:0] rs1_e_reg;
  logic [REG_ADDR_WIDTH-1:0] rs2_e_reg;
  logic                      use_rs1_e_reg;
  logic                      use_rs2_e_reg;

  logic                      e_load_next;
  logic                      taken_transfer;
  logic                      raw_hazard;
  logic [NUM_SLOTS-1:0]      rs1_e_match;
  logic [NUM_SLOTS-1:0]      rs2_e_match;
  logic [NUM_SLOTS-1:0]      rs1_d_raw;
  logic [NUM_SLOTS-1:0]      rs2_d_raw;
  logic                      tracker_unused;

  assign e_load_next = ~stallD & ~flushE;

  // Slot E takes the Decode instruction or a bubble; older slots shift unconditionally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        rd_reg[i] <= '0;
        wr_reg[i] <= 1'b0;
        ld_reg[i] <= 1'b0;
      end
      rs1_e_reg     <= '0;
      rs2_e_reg     <= '0;
      use_rs1_e_reg <= 1'b0;
      use_rs2_e_reg <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_SLOTS; i++) begin
        rd_reg[i] <= rd_reg[i-1];
        wr_reg[i] <= wr_reg[i-1];
        ld_reg[i] <= ld_reg[i-1];
      end
      if (e_load_next) begin
        rd_reg[SLOT_E] <= rdD;
        wr_reg[SLOT_E] <= regWriteD;
        ld_reg[SLOT_E] <= (resultSrcD == RESULT_SRC_MEMORY);
        rs1_e_reg      <= rs1D;
        rs2_e_reg      <= rs2D;
        use_rs1_e_reg  <= useRs1D;
        use_rs2_e_reg  <= useRs2D;
      end else begin
        rd_reg[SLOT_E] <= '0;
        wr_reg[SLOT_E] <= 1'b0;
        ld_reg[SLOT_E] <= 1'b0;
        rs1_e_reg      <= '0;
        rs2_e_reg      <= '0;
        use_rs1_e_reg  <= 1'b0;
        use_rs2_e_reg  <= 1'b0;
      end
    end
  end

  // Per-slot matches; x0 never matches so it is neither forwarded nor stalled on.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_match
      assign rs1_e_match[gi] = wr_reg[gi] && (rd_reg[gi] == rs1_e_reg) && (rs1_e_reg != '0);
      assign rs2_e_match[gi] = wr_reg[gi] && (rd_reg[gi] == rs2_e_reg) && (rs2_e_reg != '0);
      assign rs1_d_raw[gi]   = wr_reg[gi] && useRs1D && (rd_reg[gi] == rs1D) && (rs1D != '0);
      assign rs2_d_raw[gi]   = wr_reg[gi] && useRs2D && (rd_reg[gi] == rs2D) && (rs2D != '0);
    end
  endgenerate

  function automatic logic [1:0] fwd_select(input logic use_src, input logic [NUM_SLOTS-1:0] match);
    logic [1:0] sel;
    sel = FWD_NO_FORWARD;
    if (use_src) begin
      if (match[SLOT_M])          sel = FWD_COMPUTE;
      else if (match[SLOT_W])     sel = FWD_RD1_W;
      else if (match[SLOT_POSTW]) sel = FWD_RD1_POSTW;
    end
    return sel;
  endfunction

`ifdef HAZARD_FORWARDING_EN
  assign rs1ForwardSrcE = fwd_select(use_rs1_e_reg, rs1_e_match);
  assign rs2ForwardSrcE = fwd_select(use_rs2_e_reg, rs2_e_match);
  // Only a load still in E cannot be forwarded in time.
  assign raw_hazard     = ld_reg[SLOT_E] & (rs1_d_raw[SLOT_E] | rs2_d_raw[SLOT_E]);
  assign tracker_unused = ^{rs1_d_raw[NUM_SLOTS-1:1], rs2_d_raw[NUM_SLOTS-1:1],
                            rs1_e_match[SLOT_E], rs2_e_match[SLOT_E],
                            ld_reg[SLOT_M], ld_reg[SLOT_W], ld_reg[SLOT_POSTW]};
`else
  assign rs1ForwardSrcE = FWD_NO_FORWARD;
  assign rs2ForwardSrcE = FWD_NO_FORWARD;
  // Without forwarding, wait until the producer has reached PostW and committed.
  assign raw_hazard     = |(rs1_d_raw[SLOT_W:SLOT_E] | rs2_d_raw[SLOT_W:SLOT_E]);
  assign tracker_unused = ^{rs1_d_raw[SLOT_POSTW], rs2_d_raw[SLOT_POSTW],
                            fwd_select(use_rs1_e_reg, rs1_e_match),
                            fwd_select(use_rs2_e_reg, rs2_e_match),
                            ld_reg[SLOT_E], ld_reg[SLOT_M], ld_reg[SLOT_W], ld_reg[SLOT_POSTW]};
`endif

  // A taken transfer squashes the stalled instruction, so flush wins over stall.
  assign taken_transfer = (pcSrcE != PC_SRC_PCP4_I);
  assign stallF         = raw_hazard & ~taken_transfer;
  assign stallD         = raw_hazard & ~taken_transfer;
  assign flushD         = taken_transfer;
  assign flushE         = taken_transfer | raw_hazard;

endmodule
